tail_light_decoder: RTL and testbench
=====================================

# tail_light_decoder

- Receive-side companion to the turn-signal FSM.
- Samples the 6-bit tail-light output bus every clock and recovers the commanded turn mode (left, right, hazard, idle).
- Checks that the observed light patterns follow the legal sequences and counts violations.
- Sits on the light bus as an in-system monitor and gives the bench a self-checking decode of the FSM output.

## Interface

Parameters:
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- light  input  6  light bus: [5:3] = {LC,LB,LA}, [2:0] = {RA,RB,RC}.
- clr  input  1  synchronous clear of err_sticky and err_cnt.
- mode  output  2  decoded mode: 00 idle, 10 left, 01 right, 11 hazard (same encoding as the FSM's LR input).
- step  output  2  position in the current sequence: 0 idle, 1–3 for left/right, 1 for hazard-on.
- valid  output  1  the last sample was a legal transition.
- done  output  1  one-cycle pulse when a sequence completes.
- err_sticky  output  1  set on any violation; held until clr or reset.
- err_cnt  output  CNT_W  saturating count of violation entries.

## Operation

Pattern classes on the light input:
- IDLE: 000000.
- L1: 001000. L2: 011000. L3: 111000.
- R1: 000100. R2: 000110. R3: 000111.
- HZ: 111111.
- Any other pattern is UNK.

States: IDLE, L1, L2, L3, R1, R2, R3, HZ, UNK.

Legal transitions (no error):
- IDLE → IDLE, L1, R1 or HZ.
- L1 → L2 → L3 → IDLE.
- R1 → R2 → R3 → IDLE.
- HZ → IDLE.
- Sequences run to completion. An abort mid-sequence (for example L2 → IDLE) is a violation.

Violations:
- Any other pattern seen from IDLE, Lx, Rx or HZ is a violation.
- On a violation, the next state is the state matching the pattern (resync), or UNK if the pattern is unclassified.
- A violation sets err_sticky and increments err_cnt (saturating at 2^CNT_W−1).
- valid = 0 for that cycle.

UNK state:
- A classified pattern resyncs to the matching state with no further error.
- An unclassified pattern stays in UNK with no further error.
- valid = 0 for every cycle spent in UNK.

done:
- Pulses on L3→IDLE, R3→IDLE and HZ→IDLE when those transitions are legal.

mode and step are derived from the new state:
- Lx gives mode 10, step x. Rx gives mode 01, step x.
- HZ gives mode 11, step 1.
- IDLE and UNK give mode 00, step 0.

clr:
- clr clears err_sticky and err_cnt.
- If a violation occurs in the same cycle as clr, the violation wins: err_sticky = 1, err_cnt = 1.

## Timing

- Latency is one cycle. light is sampled at rising edge k; state and all outputs are registered and reflect that sample after edge k.
- There is no combinational path from inputs to outputs.
- Reset (reset_n low, asynchronous) forces:
  - state = IDLE, mode = 00, step = 0;
  - valid = 1, done = 0, err_sticky = 0, err_cnt = 0.
- Deassertion of reset_n is synchronous to the clock by the system. The first edge after release samples normally.
- Reset in the middle of a sequence discards it. The next sample is judged from IDLE.
- done and valid are one cycle wide per event. There are no multi-cycle holds.
- err_cnt at full scale stays at full scale. err_sticky still sets.

## Structure

Shared package tail_light_pkg holds:
- the state enum;
- the mode localparams (MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZ);
- the eight legal pattern constants with their bit mapping.

The FSM and the bench import the package so that both sides use the same encoding.

One sub-module, tail_light_classify, is a pure combinational map from light[5:0] to the state enum. The top holds the state register, the transition check, the counter and the output registers.

## Test plan

Clock period is 10 ns. reset_n is low for the first 20 ns.

- Reset: hold reset_n = 0 with light = 111000 → mode = 00, step = 0, valid = 1, err_cnt = 0. After release with light = 000000 → state stays IDLE with no error.
- Left sequence: light 001000, 011000, 111000, 000000 on successive edges → mode 10,10,10,00; step 1,2,3,0; done pulses on the 4th cycle only; err_cnt = 0. Repeat for right (000100, 000110, 000111, 000000) → mode 01.
- Hazard: alternate 111111 / 000000 for 6 cycles → mode 11,00 alternating; done on every return to IDLE; valid = 1 throughout.
- Abort and skip: 001000 then 000000 → valid = 0, err_sticky = 1, err_cnt = 1. Then 000000, 011000 → err_cnt = 2 and state resyncs to L2, so a following 111000 is legal.
- Unknown pattern: 010101 for 3 cycles → err_cnt increments once only, mode = 00, valid = 0. Then 000100 resyncs to R1 with no further error.
- clr and saturation: with CNT_W = 2, force 5 violations → err_cnt = 3. clr asserted alone → err_cnt = 0, err_sticky = 0. clr together with a violation → err_cnt = 1, err_sticky = 1. Assert reset_n low mid-sequence (at L2) → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tail_light_pkg.sv
// ---------------------------------------------------------------------------
// tail_light_pkg
//
// Shared definitions for the tail-light bus decoder. The decoder and its
// bench import this package, so both use the same state encoding, mode
// encoding and legal light patterns.
//
// Contents:
//   state_t        - decoder states (one per legal pattern plus UNK)
//   MODE_*         - decoded mode encoding, same as the FSM's LR input
//   PAT_*          - the eight legal light patterns
//   state_mode()   - mode reported for a given state
//   state_step()   - sequence position reported for a given state
//
// Light bus bit mapping: [5:3] = {LC,LB,LA}, [2:0] = {RA,RB,RC}.
// Left lamps light from the centre outwards (LA first), and right lamps
// do the same (RA first).
// ---------------------------------------------------------------------------
package tail_light_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_L1   = 4'd1,
        ST_L2   = 4'd2,
        ST_L3   = 4'd3,
        ST_R1   = 4'd4,
        ST_R2   = 4'd5,
        ST_R3   = 4'd6,
        ST_HZ   = 4'd7,
        ST_UNK  = 4'd8
    } state_t;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_HAZ   = 2'b11;

    //                                      LC LB LA RA RB RC
    localparam logic [5:0] PAT_IDLE = 6'b000000;
    localparam logic [5:0] PAT_L1   = 6'b001000;
    localparam logic [5:0] PAT_L2   = 6'b011000;
    localparam logic [5:0] PAT_L3   = 6'b111000;
    localparam logic [5:0] PAT_R1   = 6'b000100;
    localparam logic [5:0] PAT_R2   = 6'b000110;
    localparam logic [5:0] PAT_R3   = 6'b000111;
    localparam logic [5:0] PAT_HZ   = 6'b111111;

    // UNK reports idle: the turn mode cannot be recovered from an
    // unclassified pattern.
    function automatic logic [1:0] state_mode(input state_t s);
        logic [1:0] m;
        case (s)
            ST_L1, ST_L2, ST_L3: m = MODE_LEFT;
            ST_R1, ST_R2, ST_R3: m = MODE_RIGHT;
            ST_HZ:               m = MODE_HAZ;
            default:             m = MODE_IDLE;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] state_step(input state_t s);
        logic [1:0] p;
        case (s)
            ST_L1, ST_R1, ST_HZ: p = 2'd1;
            ST_L2, ST_R2:        p = 2'd2;
            ST_L3, ST_R3:        p = 2'd3;
            default:             p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tail_light_classify.sv
// ---------------------------------------------------------------------------
// tail_light_classify
//
// Pure combinational map from a light bus sample to the state whose
// pattern it matches. Anything that is not one of the eight legal
// patterns maps to ST_UNK.
//
// Ports:
//   light  in   6  light bus sample, [5:3] = {LC,LB,LA}, [2:0] = {RA,RB,RC}
//   cls    out     matching state (state_t)
// ---------------------------------------------------------------------------
module tail_light_classify
    import tail_light_pkg::*;
(
    input  logic [5:0] light,
    output state_t     cls
);

    always_comb begin
        cls = ST_UNK;
        case (light)
            PAT_IDLE: cls = ST_IDLE;
            PAT_L1:   cls = ST_L1;
            PAT_L2:   cls = ST_L2;
            PAT_L3:   cls = ST_L3;
            PAT_R1:   cls = ST_R1;
            PAT_R2:   cls = ST_R2;
            PAT_R3:   cls = ST_R3;
            PAT_HZ:   cls = ST_HZ;
            default:  cls = ST_UNK;
        endcase
    end

endmodule

// File: rtl/tail_light_decoder.sv
// ---------------------------------------------------------------------------
// tail_light_decoder
//
// In-system monitor for the turn-signal FSM's tail-light bus. Every clock
// it samples the light bus, recovers the commanded turn mode, checks that
// the pattern sequence is legal and counts violations.
//
// Parameters:
//   CNT_W       width of the saturating violation counter
//
// Ports:
//   clk         in   1      system clock, rising edge
//   reset_n     in   1      asynchronous active-low reset
//   light       in   6      light bus, [5:3] = {LC,LB,LA}, [2:0] = {RA,RB,RC}
//   clr         in   1      synchronous clear of err_sticky / err_cnt
//   mode        out  2      00 idle, 10 left, 01 right, 11 hazard
//   step        out  2      position in the current sequence (0..3)
//   valid       out  1      last sample was a legal transition
//   done        out  1      one-cycle pulse when a sequence completes
//   err_sticky  out  1      set on any violation, held until clr/reset
//   err_cnt     out  CNT_W  saturating count of violations
//
// All outputs are registered; there is one cycle of latency from a light
// sample to the outputs that describe it.
// ---------------------------------------------------------------------------
module tail_light_decoder
    import tail_light_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       light,
    input  logic             clr,
    output logic [1:0]       mode,
    output logic [1:0]       step,
    output logic             valid,
    output logic             done,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    state_t cls;
    logic   legal;
    logic   violation;
    logic   seq_done;

    tail_light_classify u_classify (
        .light (light),
        .cls   (cls)
    );

    // Transition check. The next state is always the class of the sample:
    // a legal step lands there, a violation resyncs there, and an
    // unclassified pattern lands in UNK. Only the error bookkeeping
    // depends on where we came from. UNK never raises further errors, but
    // nothing leaving it counts as a legal transition either.
    always_comb begin
        legal = 1'b0;
        case (state)
            ST_IDLE: legal = (cls == ST_IDLE) || (cls == ST_L1) ||
                             (cls == ST_R1)   || (cls == ST_HZ);
            ST_L1:   legal = (cls == ST_L2);
            ST_L2:   legal = (cls == ST_L3);
            ST_R1:   legal = (cls == ST_R2);
            ST_R2:   legal = (cls == ST_R3);
            ST_L3, ST_R3, ST_HZ:
                     legal = (cls == ST_IDLE);
            default: legal = 1'b0;
        endcase
        violation = !legal && (state != ST_UNK);
        seq_done  = legal && ((state == ST_L3) || (state == ST_R3) ||
                              (state == ST_HZ));
    end

    // State and output registers. A violation in the same cycle as clr
    // wins, so the counter restarts at one rather than zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mode       <= MODE_IDLE;
            step       <= 2'd0;
            valid      <= 1'b1;
            done       <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state <= cls;
            mode  <= state_mode(cls);
            step  <= state_step(cls);
            valid <= legal;
            done  <= seq_done;
            if (violation) begin
                err_sticky <= 1'b1;
                if (clr) begin
                    err_cnt <= CNT_ONE;
                end else if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end else if (clr) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tail_light_decoder.sv
// ---------------------------------------------------------------------------
// tb_tail_light_decoder
//
// Self-checking bench for tail_light_decoder. Two instances share the
// stimulus: one with the default 8-bit counter and one with a 2-bit
// counter to reach saturation quickly. Expected outputs are computed by a
// small behavioural model when each sample is driven, pushed to a queue,
// and popped and compared one clock later.
// ---------------------------------------------------------------------------
module tb_tail_light_decoder;
    import tail_light_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] light = 6'b111000;

    logic [1:0] mode, step, mode_s, step_s;
    logic       valid, done, err_sticky;
    logic       valid_s, done_s, err_sticky_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        string      tag;
        logic [1:0] mode;
        logic [1:0] step;
        logic       valid;
        logic       done;
        logic       sticky;
        int         cnt8;
        int         cnt2;
    } exp_t;

    exp_t scoreboard[$];

    // Behavioural model state
    int   mState;      // 0 idle, 1..3 L, 4..6 R, 7 HZ, 8 unknown
    int   mCnt8;
    int   mCnt2;
    logic mSticky;

    tail_light_decoder #(.CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .light(light), .clr(clr),
        .mode(mode), .step(step), .valid(valid), .done(done),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    tail_light_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .light(light), .clr(clr),
        .mode(mode_s), .step(step_s), .valid(valid_s), .done(done_s),
        .err_sticky(err_sticky_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modelClass(input logic [5:0] p);
        case (p)
            6'b000000: return 0;
            6'b001000: return 1;
            6'b011000: return 2;
            6'b111000: return 3;
            6'b000100: return 4;
            6'b000110: return 5;
            6'b000111: return 6;
            6'b111111: return 7;
            default:   return 8;
        endcase
    endfunction

    // Drive one sample at the falling edge, predict the result, then
    // check it just after the following rising edge.
    task automatic applyStimulus(input string tag, input logic [5:0] pat, input logic c);
        exp_t e;
        int   k;
        logic ok;
        light = pat;
        clr   = c;
        k = modelClass(pat);
        case (mState)
            0:       ok = (k == 0) || (k == 1) || (k == 4) || (k == 7);
            1, 2:    ok = (k == mState + 1);
            4, 5:    ok = (k == mState + 1);
            3, 6, 7: ok = (k == 0);
            default: ok = 1'b0;
        endcase
        e.tag   = tag;
        e.valid = ok;
        e.done  = ok && (mState == 3 || mState == 6 || mState == 7);
        if (!ok && mState != 8) begin
            mSticky = 1'b1;
            if (c) begin
                mCnt8 = 1;
                mCnt2 = 1;
            end else begin
                if (mCnt8 < 255) mCnt8++;
                if (mCnt2 < 3) mCnt2++;
            end
        end else if (c) begin
            mSticky = 1'b0;
            mCnt8 = 0;
            mCnt2 = 0;
        end
        mState = k;
        if (k >= 1 && k <= 3) begin
            e.mode = 2'b10; e.step = 2'(k);
        end else if (k >= 4 && k <= 6) begin
            e.mode = 2'b01; e.step = 2'(k - 3);
        end else if (k == 7) begin
            e.mode = 2'b11; e.step = 2'd1;
        end else begin
            e.mode = 2'b00; e.step = 2'd0;
        end
        e.sticky = mSticky;
        e.cnt8   = mCnt8;
        e.cnt2   = mCnt2;
        scoreboard.push_back(e);

        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checkOutput({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({e.tag, ".mode"},   int'(mode),       int'(e.mode));
            checkOutput({e.tag, ".step"},   int'(step),       int'(e.step));
            checkOutput({e.tag, ".valid"},  int'(valid),      int'(e.valid));
            checkOutput({e.tag, ".done"},   int'(done),       int'(e.done));
            checkOutput({e.tag, ".sticky"}, int'(err_sticky), int'(e.sticky));
            checkOutput({e.tag, ".cnt"},    int'(err_cnt),    e.cnt8);
            checkOutput({e.tag, ".cnt_s"},  int'(err_cnt_s),  e.cnt2);
            checkOutput({e.tag, ".sticky_s"}, int'(err_sticky_s), int'(e.sticky));
        end
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".mode"},   int'(mode),         0);
        checkOutput({tag, ".step"},   int'(step),         0);
        checkOutput({tag, ".valid"},  int'(valid),        1);
        checkOutput({tag, ".done"},   int'(done),         0);
        checkOutput({tag, ".sticky"}, int'(err_sticky),   0);
        checkOutput({tag, ".cnt"},    int'(err_cnt),      0);
        checkOutput({tag, ".cnt_s"},  int'(err_cnt_s),    0);
        checkOutput({tag, ".mode_s"}, int'(mode_s),       0);
    endtask

    initial begin
        logic [5:0] leftSeq[4];
        logic [5:0] rightSeq[4];
        leftSeq  = '{6'b001000, 6'b011000, 6'b111000, 6'b000000};
        rightSeq = '{6'b000100, 6'b000110, 6'b000111, 6'b000000};
        mState = 0; mCnt8 = 0; mCnt2 = 0; mSticky = 1'b0;

        // Reset held across a rising edge with a left-lamp pattern present
        #12;
        checkReset("reset");
        #8;
        light   = 6'b000000;
        reset_n = 1'b1;

        applyStimulus("idle", 6'b000000, 1'b0);

        foreach (leftSeq[i])  applyStimulus("left", leftSeq[i], 1'b0);
        foreach (rightSeq[i]) applyStimulus("right", rightSeq[i], 1'b0);

        for (int i = 0; i < 6; i++)
            applyStimulus("hazard", (i % 2 == 0) ? 6'b111111 : 6'b000000, 1'b0);

        // Abort mid-sequence, then a skip straight to L2 which resyncs
        applyStimulus("abort_l1", 6'b001000, 1'b0);
        applyStimulus("abort",    6'b000000, 1'b0);
        applyStimulus("abort_id", 6'b000000, 1'b0);
        applyStimulus("skip_l2",  6'b011000, 1'b0);
        applyStimulus("resync_l3", 6'b111000, 1'b0);
        applyStimulus("resync_id", 6'b000000, 1'b0);

        // Unclassified pattern counts once, then resync to R1
        for (int i = 0; i < 3; i++) applyStimulus("unknown", 6'b010101, 1'b0);
        applyStimulus("unk_r1", 6'b000100, 1'b0);
        applyStimulus("unk_r2", 6'b000110, 1'b0);
        applyStimulus("unk_r3", 6'b000111, 1'b0);
        applyStimulus("unk_id", 6'b000000, 1'b0);

        // Clear, then five violations to saturate the 2-bit counter
        applyStimulus("clr_idle", 6'b000000, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus("sat", (i % 2 == 0) ? 6'b011000 : 6'b000000, 1'b0);
        applyStimulus("clr_alone", 6'b111000, 1'b1);
        applyStimulus("clr_done",  6'b000000, 1'b0);
        applyStimulus("clr_viol",  6'b011000, 1'b1);

        // Asynchronous reset while sitting in L2
        #2;
        reset_n = 1'b0;
        #1;
        checkReset("async_reset");
        mState = 0; mCnt8 = 0; mCnt2 = 0; mSticky = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("post_reset_l1", 6'b001000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
